// File: rtl/cam_pkg.sv
// Shared state encoding and default frame geometry for the camera capture front-end.
package cam_pkg;

    localparam int CAM_H_MAX = 640;
    localparam int CAM_V_MAX = 480;
    localparam int CAM_XW    = 10;
    localparam int CAM_YW    = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_ACTIVE,
        ST_DONE
    } cam_state_e;

endpackage

// File: rtl/cam_sync_edge.sv
// Three-flop synchronizer for asynchronous camera strobes, with edge detection on the
// second and third stages.
module cam_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic [W-1:0] s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/cam_capture.sv
// Camera bus capture: oversamples PCLK/HREF/VSYNC, pairs bytes into 16-bit pixels with
// x/y tags, and presents them through a single valid/ready output register.
//
// state      | meaning
// ST_IDLE    | capture disarmed, waiting for CAP_EN
// ST_WAIT_VS | armed, waiting for the VSYNC fall that starts a frame
// ST_ACTIVE  | frame in progress, bytes are assembled into pixels
// ST_DONE    | one cycle: frame finished, count already incremented
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_MAX = CAM_H_MAX,
    parameter int V_MAX = CAM_V_MAX,
    parameter int XW    = CAM_XW,
    parameter int YW    = CAM_YW
) (
    input  logic          xipMCLK,
    input  logic          xipRESET,
    input  logic          xipCAM_VSYNC,
    input  logic          xipCAM_HREF,
    input  logic          xipCAM_PCLK,
    input  logic [7:0]    xipCAM_D,
    input  logic          xipCAP_EN,
    input  logic          xipPIX_READY,
    output logic [15:0]   xopPIX_DATA,
    output logic [XW-1:0] xopPIX_X,
    output logic [YW-1:0] xopPIX_Y,
    output logic          xopPIX_VALID,
    output logic          xopFRAME_START,
    output logic          xopFRAME_DONE,
    output logic          xopOVERFLOW,
    output logic [7:0]    xopFRAME_CNT
);

    localparam logic [XW:0] H_LIM = (XW+1)'(H_MAX);
    localparam logic [YW:0] V_LIM = (YW+1)'(V_MAX);

    logic pclk_s2, pclk_rise, pclk_fall;
    logic vs_s2, vs_rise, vs_fall;
    logic href_s2, href_rise, href_fall;
    logic unused_sync;

    cam_sync_edge #(.W(1)) u_pclk (
        .clk(xipMCLK), .rst(xipRESET), .din(xipCAM_PCLK),
        .sync(pclk_s2), .rise(pclk_rise), .fall(pclk_fall)
    );

    cam_sync_edge #(.W(1)) u_vsync (
        .clk(xipMCLK), .rst(xipRESET), .din(xipCAM_VSYNC),
        .sync(vs_s2), .rise(vs_rise), .fall(vs_fall)
    );

    cam_sync_edge #(.W(1)) u_href (
        .clk(xipMCLK), .rst(xipRESET), .din(xipCAM_HREF),
        .sync(href_s2), .rise(href_rise), .fall(href_fall)
    );

    assign unused_sync = ^{pclk_s2, pclk_fall, vs_s2, href_rise};

    cam_state_e     state_q, state_d;
    logic [7:0]     d_s1_q, d_s2_q;
    logic           fs_q, fs_d, fd_q, fd_d, ovf_q, ovf_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           phase_q, phase_d;
    logic [7:0]     hi_q, hi_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           asm_vld_q, asm_vld_d;
    logic [15:0]    asm_data_q, asm_data_d;
    logic [XW-1:0]  asm_x_q, asm_x_d;
    logic [YW-1:0]  asm_y_q, asm_y_d;
    logic           vld_q, vld_d;
    logic [15:0]    data_q, data_d;
    logic [XW-1:0]  px_q, px_d;
    logic [YW-1:0]  py_q, py_d;

    always_comb begin
        state_d    = state_q;
        fs_d       = 1'b0;
        fd_d       = 1'b0;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        x_d        = x_q;
        y_d        = y_q;
        asm_vld_d  = 1'b0;
        asm_data_d = asm_data_q;
        asm_x_d    = asm_x_q;
        asm_y_d    = asm_y_q;
        vld_d      = vld_q;
        data_d     = data_q;
        px_d       = px_q;
        py_d       = py_q;

        case (state_q)
            ST_IDLE: begin
                if (xipCAP_EN) state_d = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (vs_fall) begin
                    state_d = ST_ACTIVE;
                    fs_d    = 1'b1;
                    ovf_d   = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (vs_rise) begin
                    state_d = ST_DONE;
                    fd_d    = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
                if (href_fall) begin
                    x_d     = '0;
                    phase_d = 1'b0;
                    if (x_q != '0 && !(&y_q)) y_d = y_q + YW'(1);
                end else if (!href_s2) begin
                    phase_d = 1'b0;
                end else if (pclk_rise) begin
                    if (!phase_q) begin
                        hi_d    = d_s2_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d    = 1'b0;
                        asm_data_d = {hi_q, d_s2_q};
                        asm_x_d    = x_q;
                        asm_y_d    = y_q;
                        asm_vld_d  = ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);
                        if (!(&x_q)) x_d = x_q + XW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = xipCAP_EN ? ST_WAIT_VS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A load wins over a plain accept so a simultaneous handshake keeps VALID high.
        if (asm_vld_q) begin
            if (!vld_q || xipPIX_READY) begin
                vld_d  = 1'b1;
                data_d = asm_data_q;
                px_d   = asm_x_q;
                py_d   = asm_y_q;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (xipPIX_READY) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge xipMCLK) begin
        if (xipRESET) begin
            state_q    <= ST_IDLE;
            d_s1_q     <= '0;
            d_s2_q     <= '0;
            fs_q       <= 1'b0;
            fd_q       <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            asm_vld_q  <= 1'b0;
            asm_data_q <= '0;
            asm_x_q    <= '0;
            asm_y_q    <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            px_q       <= '0;
            py_q       <= '0;
        end else begin
            state_q    <= state_d;
            d_s1_q     <= xipCAM_D;
            d_s2_q     <= d_s1_q;
            fs_q       <= fs_d;
            fd_q       <= fd_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            x_q        <= x_d;
            y_q        <= y_d;
            asm_vld_q  <= asm_vld_d;
            asm_data_q <= asm_data_d;
            asm_x_q    <= asm_x_d;
            asm_y_q    <= asm_y_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            px_q       <= px_d;
            py_q       <= py_d;
        end
    end

    assign xopPIX_DATA    = data_q;
    assign xopPIX_X       = px_q;
    assign xopPIX_Y       = py_q;
    assign xopPIX_VALID   = vld_q;
    assign xopFRAME_START = fs_q;
    assign xopFRAME_DONE  = fd_q;
    assign xopOVERFLOW    = ovf_q;
    assign xopFRAME_CNT   = cnt_q;

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture: a default-geometry instance plus a narrow
// (H_MAX = 2) instance that always accepts, both fed from the same camera bus.
module tb_cam_capture;
    import cam_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic [9:0]  x;
        logic [8:0]  y;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst, vsync, href, pclk, cap_en, ready;
    logic [7:0]  cam_d;

    logic [15:0] pix_data, c_pix_data;
    logic [9:0]  pix_x, c_pix_x;
    logic [8:0]  pix_y, c_pix_y;
    logic        pix_valid, c_pix_valid;
    logic        fstart, c_fstart, fdone, c_fdone, ovf, c_ovf;
    logic [7:0]  fcnt, c_fcnt;

    always #5 clk = ~clk;

    cam_capture dut (
        .xipMCLK(clk), .xipRESET(rst), .xipCAM_VSYNC(vsync), .xipCAM_HREF(href),
        .xipCAM_PCLK(pclk), .xipCAM_D(cam_d), .xipCAP_EN(cap_en), .xipPIX_READY(ready),
        .xopPIX_DATA(pix_data), .xopPIX_X(pix_x), .xopPIX_Y(pix_y), .xopPIX_VALID(pix_valid),
        .xopFRAME_START(fstart), .xopFRAME_DONE(fdone), .xopOVERFLOW(ovf), .xopFRAME_CNT(fcnt)
    );

    cam_capture #(.H_MAX(2), .V_MAX(480), .XW(10), .YW(9)) dut_clip (
        .xipMCLK(clk), .xipRESET(rst), .xipCAM_VSYNC(vsync), .xipCAM_HREF(href),
        .xipCAM_PCLK(pclk), .xipCAM_D(cam_d), .xipCAP_EN(cap_en), .xipPIX_READY(1'b1),
        .xopPIX_DATA(c_pix_data), .xopPIX_X(c_pix_x), .xopPIX_Y(c_pix_y), .xopPIX_VALID(c_pix_valid),
        .xopFRAME_START(c_fstart), .xopFRAME_DONE(c_fdone), .xopOVERFLOW(c_ovf), .xopFRAME_CNT(c_fcnt)
    );

    pix_t       q_main[$];
    pix_t       q_clip[$];
    int         checks = 0;
    int         errors = 0;
    int         fs_seen = 0;
    int         fd_seen = 0;
    bit         sup_main = 1'b0;
    bit         sup_clip = 1'b0;
    int         cur_y = 0;
    logic [7:0] exp_cnt = 8'd0;

    // Scoreboard: a pixel is consumed on every cycle where VALID and READY meet.
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid && ready) begin
                checks++;
                if (q_main.size() == 0) begin
                    errors++;
                    $display("FAIL pix_main_unexpected got %h/%0d/%0d exp none", pix_data, pix_x, pix_y);
                end else begin
                    pix_t e;
                    e = q_main.pop_front();
                    if ({pix_data, pix_x, pix_y} !== e) begin
                        errors++;
                        $display("FAIL pix_main got %h/%0d/%0d exp %h/%0d/%0d",
                                 pix_data, pix_x, pix_y, e.data, e.x, e.y);
                    end
                end
            end
            if (c_pix_valid) begin
                checks++;
                if (q_clip.size() == 0) begin
                    errors++;
                    $display("FAIL pix_clip_unexpected got %h/%0d/%0d exp none", c_pix_data, c_pix_x, c_pix_y);
                end else begin
                    pix_t e;
                    e = q_clip.pop_front();
                    if ({c_pix_data, c_pix_x, c_pix_y} !== e) begin
                        errors++;
                        $display("FAIL pix_clip got %h/%0d/%0d exp %h/%0d/%0d",
                                 c_pix_data, c_pix_x, c_pix_y, e.data, e.x, e.y);
                    end
                end
            end
            if (fstart) fs_seen++;
            if (fdone)  fd_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_d = b;
        pclk  = 1'b0;
        cyc(4);
        pclk  = 1'b1;
        cyc(4);
    endtask

    task automatic send_line(input logic [7:0] base, input int nbytes);
        href = 1'b1;
        cyc(2);
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            b = base + 8'(i);
            if (i % 2 == 1) begin
                pix_t p;
                p.data = {b - 8'd1, b};
                p.x    = 10'(i / 2);
                p.y    = 9'(cur_y);
                if (!sup_main && (i / 2) < CAM_H_MAX && cur_y < CAM_V_MAX) q_main.push_back(p);
                if (!sup_clip && (i / 2) < 2) q_clip.push_back(p);
            end
            send_byte(b);
        end
        pclk = 1'b0;
        cyc(4);
        href = 1'b0;
        cyc(8);
        if (nbytes >= 2) cur_y++;
    endtask

    task automatic frame_begin();
        vsync = 1'b1;
        cyc(4);
        vsync = 1'b0;
        cyc(6);
        cur_y = 0;
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        cyc(8);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (q_main.size() != 0 || q_clip.size() != 0) begin
            errors++;
            $display("FAIL %s_drained got main=%0d clip=%0d pending exp 0", name, q_main.size(), q_clip.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b1; href = 1'b0; pclk = 1'b0; cam_d = 8'h00;
        cap_en = 1'b0; ready = 1'b1;
        cyc(3);
        checks++;
        if ({pix_valid, fstart, fdone, ovf} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {pix_valid, fstart, fdone, ovf});
        end
        checks++;
        if ({pix_data, pix_x, pix_y} !== 35'd0) begin
            errors++;
            $display("FAIL reset_pixel got %h/%0d/%0d exp 0", pix_data, pix_x, pix_y);
        end
        checks++;
        if (fcnt !== 8'd0 || c_pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt got cnt=%0d cvalid=%b exp 0/0", fcnt, c_pix_valid);
        end
        rst = 1'b0;
        cyc(4);
    endtask

    task automatic test_frame();
        int fs0, fd0;
        fs0 = fs_seen; fd0 = fd_seen;
        cap_en = 1'b1;
        cyc(2);
        frame_begin();
        send_line(8'h00, 8);
        send_line(8'h08, 8);
        frame_end();
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (fs_seen - fs0 != 1 || fd_seen - fd0 != 1) begin
            errors++;
            $display("FAIL frame_pulses got start=%0d done=%0d exp 1/1", fs_seen - fs0, fd_seen - fd0);
        end
        checks++;
        if (fcnt !== exp_cnt || ovf !== 1'b0) begin
            errors++;
            $display("FAIL frame_cnt got cnt=%0d ovf=%b exp %0d/0", fcnt, ovf, exp_cnt);
        end
        check_drained("frame");
    endtask

    task automatic test_latency();
        int k;
        pix_t p;
        frame_begin();
        href = 1'b1;
        cyc(2);
        send_byte(8'hA0);
        p.data = 16'hA0A1; p.x = 10'd0; p.y = 9'd0;
        q_main.push_back(p);
        q_clip.push_back(p);
        cam_d = 8'hA1;
        pclk  = 1'b0;
        cyc(4);
        pclk  = 1'b1;
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (pix_valid !== 1'b1 && k < 20);
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL latency got %0d edges exp 4", k);
        end
        cyc(3);
        pclk = 1'b0;
        cyc(4);
        href = 1'b0;
        cyc(8);
        frame_end();
        exp_cnt = exp_cnt + 8'd1;
        check_drained("latency");
    endtask

    task automatic test_backpressure();
        pix_t p;
        frame_begin();
        ready = 1'b0;
        p.data = 16'h0001; p.x = 10'd0; p.y = 9'd0;
        q_main.push_back(p);
        sup_main = 1'b1;
        send_line(8'h00, 6);
        sup_main = 1'b0;
        checks++;
        if (ovf !== 1'b1 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_overflow got ovf=%b valid=%b exp 1/1", ovf, pix_valid);
        end
        checks++;
        if (pix_data !== 16'h0001) begin
            errors++;
            $display("FAIL bp_held got %h exp 0001", pix_data);
        end
        ready = 1'b1;
        cyc(3);
        frame_end();
        exp_cnt = exp_cnt + 8'd1;
        frame_begin();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_ovf_clear got %b exp 0", ovf);
        end
        frame_end();
        exp_cnt = exp_cnt + 8'd1;
        check_drained("bp");
    endtask

    task automatic test_clipping();
        frame_begin();
        send_line(8'h20, 8);
        send_line(8'h30, 7);
        send_line(8'h40, 4);
        frame_end();
        exp_cnt = exp_cnt + 8'd1;
        check_drained("clip");
        checks++;
        if (fcnt !== exp_cnt) begin
            errors++;
            $display("FAIL clip_cnt got %0d exp %0d", fcnt, exp_cnt);
        end
    endtask

    task automatic test_cap_en_drop();
        int fs0, fd0;
        fd0 = fd_seen;
        frame_begin();
        send_line(8'h60, 4);
        cap_en = 1'b0;
        send_line(8'h64, 4);
        frame_end();
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (fd_seen - fd0 != 1 || fcnt !== exp_cnt) begin
            errors++;
            $display("FAIL capdrop_done got done=%0d cnt=%0d exp 1/%0d", fd_seen - fd0, fcnt, exp_cnt);
        end
        fs0 = fs_seen; fd0 = fd_seen;
        sup_main = 1'b1; sup_clip = 1'b1;
        frame_begin();
        send_line(8'h70, 4);
        frame_end();
        sup_main = 1'b0; sup_clip = 1'b0;
        checks++;
        if (fs_seen != fs0 || fd_seen != fd0) begin
            errors++;
            $display("FAIL capdrop_idle got start=%0d done=%0d exp 0/0", fs_seen - fs0, fd_seen - fd0);
        end
        check_drained("capdrop");
        cap_en = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset_mid();
        int fs0, fd0;
        frame_begin();
        send_line(8'h80, 4);
        href = 1'b1;
        cyc(2);
        send_byte(8'h90);
        begin
            pix_t p;
            p.data = 16'h9091; p.x = 10'd0; p.y = 9'(cur_y);
            q_main.push_back(p);
            q_clip.push_back(p);
        end
        send_byte(8'h91);
        pclk = 1'b0;
        cyc(4);
        fd0 = fd_seen;
        rst = 1'b1;
        cyc(1);
        checks++;
        if ({pix_valid, fstart, fdone, ovf} !== 4'b0 || {pix_data, pix_x, pix_y} !== 35'd0) begin
            errors++;
            $display("FAIL midrst_out got v=%b d=%h x=%0d y=%0d exp all 0", pix_valid, pix_data, pix_x, pix_y);
        end
        checks++;
        if (fcnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_cnt got %0d exp 0", fcnt);
        end
        rst = 1'b0;
        exp_cnt = 8'd0;
        sup_main = 1'b1; sup_clip = 1'b1;
        send_byte(8'h92);
        send_byte(8'h93);
        pclk = 1'b0;
        cyc(4);
        href = 1'b0;
        cyc(8);
        frame_end();
        sup_main = 1'b0; sup_clip = 1'b0;
        checks++;
        if (fd_seen != fd0) begin
            errors++;
            $display("FAIL midrst_nodone got %0d exp 0", fd_seen - fd0);
        end
        fs0 = fs_seen; fd0 = fd_seen;
        frame_begin();
        send_line(8'hB0, 4);
        frame_end();
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (fs_seen - fs0 != 1 || fd_seen - fd0 != 1 || fcnt !== exp_cnt) begin
            errors++;
            $display("FAIL midrst_resume got start=%0d done=%0d cnt=%0d exp 1/1/%0d",
                     fs_seen - fs0, fd_seen - fd0, fcnt, exp_cnt);
        end
        check_drained("midrst");
    endtask

    task automatic test_wrap();
        int fd0;
        fd0 = fd_seen;
        for (int f = 0; f < 256; f++) begin
            frame_begin();
            frame_end();
            exp_cnt = exp_cnt + 8'd1;
            if (exp_cnt == 8'd255 || exp_cnt == 8'd0) begin
                checks++;
                if (fcnt !== exp_cnt) begin
                    errors++;
                    $display("FAIL wrap_cnt got %0d exp %0d", fcnt, exp_cnt);
                end
            end
        end
        checks++;
        if (fd_seen - fd0 != 256 || fcnt !== exp_cnt) begin
            errors++;
            $display("FAIL wrap_total got done=%0d cnt=%0d exp 256/%0d", fd_seen - fd0, fcnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_latency();
        test_backpressure();
        test_clipping();
        test_cap_en_drop();
        test_reset_mid();
        test_wrap();
        check_drained("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
